instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Multicycle instruction-fetch stage directly upstream of the opcode control decoder. Owns the program counter, issues word reads to instruction memory, waits a fixed memory latency, latches the returned word into the instruction register, and presents decoded fields (opcode, funct, rs, rt, rd, shamt, imm16, jaddr) to the decoder with a valid/ready handshake. Accepts PC redirects for jumps, branches, rte and break, and traps misaligned redirect targets to an exception vector.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from the FETCH cycle until mem_data is valid; legal range 1..15
- RESET_PC, 32'h0000_0000, PC value after reset
- EXC_VECTOR, 32'h0000_00FD, PC loaded on a misaligned redirect

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  out  32  instruction memory address; always equals pc
- mem_rd  out  1  read strobe, high only in FETCH
- mem_data  in  32  memory read data
- pc_load  in  1  redirect request
- pc_target  in  32  redirect address
- dec_ready  in  1  decoder accepts the current instruction
- ir_valid  out  1  IR holds an unconsumed instruction
- opcode  out  6  IR[31:26]
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- funct  out  6  IR[5:0]
- imm16  out  16  IR[15:0]
- jaddr  out  26  IR[25:0]
- pc  out  32  address of the next fetch
- pc_plus4  out  32  address of the IR instruction + 4 (jal link value)
- exc_misaligned  out  1  one-cycle pulse on a misaligned redirect

## Operation
- States: BOOT, FETCH, WAIT, HOLD. Reset state BOOT.
- BOOT: one cycle, mem_rd=0, -> FETCH.
- FETCH: mem_rd=1; load wait counter with MEM_LATENCY-1; -> WAIT.
- WAIT: counter decrements each cycle. When counter==0: IR <= mem_data, pc <= pc+4, pc_plus4 <= pc+4, ir_valid <= 1, -> HOLD.
- HOLD: ir_valid=1; IR and fields stable. On ir_valid && dec_ready: ir_valid <= 0, -> FETCH.
- Redirect (pc_load=1), priority over every other transition, any state except BOOT:
  - pc_target[1:0]==0: pc <= pc_target. Otherwise pc <= EXC_VECTOR, exc_misaligned=1 for the next cycle.
  - ir_valid <= 0; IR contents left unchanged, fields not re-zeroed.
  - Next state FETCH. A read in flight in WAIT is abandoned; its data is never captured.
  - In HOLD with dec_ready=1 in the same cycle, the instruction counts as consumed and the redirect still applies.
- pc_load in BOOT is ignored.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- mem_addr = pc combinationally; the address does not change between FETCH and capture unless redirected.

## Timing
- Reset values (held while rst_n=0): pc=RESET_PC, pc_plus4=0, IR=0 (all fields 0), ir_valid=0, mem_rd=0, exc_misaligned=0, state BOOT, counter 0.
- Fetch latency, FETCH in cycle k: mem_data sampled at the end of cycle k+MEM_LATENCY; ir_valid high from cycle k+MEM_LATENCY+1.
- Throughput with dec_ready tied high: one instruction per MEM_LATENCY+2 cycles.
- Reset asserted mid-operation clears everything immediately; no partial capture. First mem_rd occurs in the second cycle after rst_n rises.
- dec_ready is ignored when ir_valid=0.

## Test plan
- MEM_LATENCY=2, RESET_PC=0, mem[0]=32'h20090005 -> BOOT at cycle 0, mem_rd at cycle 1, ir_valid from cycle 4 with opcode=8, rs=0, rt=9, imm16=5, pc=4, pc_plus4=4.
- dec_ready held low 5 cycles after ir_valid -> fields stable, no mem_rd; dec_ready=1 -> next FETCH at addr 4 the following cycle.
- pc_load=1, pc_target=32'h40 during WAIT -> in-flight data discarded, next mem_rd at addr 32'h40, IR captures mem[32'h40].
- pc_load=1, pc_target=32'h42 -> pc=32'hFD, exc_misaligned high exactly one cycle, next fetch at 32'hFD.
- RESET_PC=32'hFFFF_FFFC -> after the first capture, pc=0 and pc_plus4=0 (wrap).
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously; the fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle instruction fetch with PC redirect and decoded IR fields
module instr_fetch_unit #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_00FD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    input  logic        dec_ready,
    output logic        ir_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        exc_misaligned
);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        exc_q, exc_d;
    logic [31:0] pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            cnt_q      <= 4'd0;
            pc_q       <= RESET_PC;
            pc_plus4_q <= 32'd0;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            exc_q      <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        exc_d      = 1'b0;
        pc_inc     = pc_q + 32'd4;

        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    ir_d       = mem_data;
                    pc_d       = pc_inc;
                    pc_plus4_d = pc_inc;
                    ir_valid_d = 1'b1;
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (ir_valid_q && dec_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        // Redirect overrides the above; an in-flight read is simply never captured.
        if (pc_load && (state_q != BOOT)) begin
            if (pc_target[1:0] == 2'b00) begin
                pc_d = pc_target;
            end else begin
                pc_d  = EXC_VECTOR;
                exc_d = 1'b1;
            end
            ir_valid_d = 1'b0;
            state_d    = FETCH;
        end
    end

    assign mem_addr       = pc_q;
    assign mem_rd         = (state_q == FETCH);
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_q;
    assign ir_valid       = ir_valid_q;
    assign exc_misaligned = exc_q;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign jaddr  = ir_q[25:0];

endmodule
